// File: rtl/datapath_seq_ctrl.sv
// datapath_seq_ctrl
//   Moore sequencer for the four-register datapath. Each accepted start runs
//   one load/shift/store operation in this order:
//     LOAD_A -> LOAD_B -> MUX -> SHIFT x nshift -> STORE_C -> DONE x DONE_HOLD
//   It then returns to IDLE. The controller drives the register enables and the
//   mux select, so no caller has to toggle them by hand.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      level request; only a rising edge seen while IDLE is accepted
//   abort      synchronous cancel; returns any non-IDLE state to IDLE
//   nshift     shift count, captured when a start is accepted
//   ena/enb    load enables for registers A and B
//   enc        load enable for result register C
//   enshift    shift-register enable
//   selectMux  0 = data input path, 1 = register/shift path
//   busy       high in LOAD_A..STORE_C
//   done       high in DONE
//   state_led  current state code (IDLE=0 .. DONE=6)
module datapath_seq_ctrl #(
  parameter int SHIFT_W   = 3,
  parameter int DONE_HOLD = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [SHIFT_W-1:0] nshift,
  output logic               ena,
  output logic               enb,
  output logic               enc,
  output logic               enshift,
  output logic               selectMux,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_led
);

  // The hold counter runs 0 .. DONE_HOLD-1 while in DONE.
  localparam int HOLD_W = (DONE_HOLD > 1) ? $clog2(DONE_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    MUX     = 3'd3,
    SHIFT   = 3'd4,
    STORE_C = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic               start_q, start_d;
  logic [SHIFT_W-1:0] cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  // The outputs are flops loaded from the decode of the next state. They
  // therefore always equal the decode of the registered state.
  logic ena_q, ena_d;
  logic enb_q, enb_d;
  logic enc_q, enc_d;
  logic enshift_q, enshift_d;
  logic sel_q, sel_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [2:0] led_q, led_d;

  logic start_edge;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = hold_q;
    start_d    = start;
    start_edge = start & ~start_q;

    case (state_q)
      IDLE: begin
        if (start_edge) begin
          state_d = LOAD_A;
          cnt_d   = nshift;
        end
      end
      LOAD_A:  state_d = LOAD_B;
      LOAD_B:  state_d = MUX;
      MUX:     state_d = (cnt_q != '0) ? SHIFT : STORE_C;
      SHIFT: begin
        cnt_d = cnt_q - SHIFT_W'(1);
        // Leave on the last shift so exactly nshift SHIFT cycles occur.
        // The counter never goes below zero, so it cannot wrap.
        if (cnt_q <= SHIFT_W'(1)) begin
          state_d = STORE_C;
        end
      end
      STORE_C: begin
        state_d = DONE;
        hold_d  = '0;
      end
      DONE: begin
        if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;  // unused code 7 recovers to IDLE
    endcase

    // Abort overrides every exit from a non-IDLE state. This includes
    // DONE -> IDLE and STORE_C -> DONE, so an aborted run never shows done.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end

    ena_d     = (state_d == LOAD_A);
    enb_d     = (state_d == LOAD_B);
    enc_d     = (state_d == STORE_C);
    enshift_d = (state_d == SHIFT);
    sel_d     = (state_d == MUX) || (state_d == SHIFT) || (state_d == STORE_C);
    busy_d    = (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == MUX) ||
                (state_d == SHIFT)  || (state_d == STORE_C);
    done_d    = (state_d == DONE);
    led_d     = state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      cnt_q     <= '0;
      hold_q    <= '0;
      ena_q     <= 1'b0;
      enb_q     <= 1'b0;
      enc_q     <= 1'b0;
      enshift_q <= 1'b0;
      sel_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= 3'd0;
    end else begin
      state_q   <= state_d;
      start_q   <= start_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      ena_q     <= ena_d;
      enb_q     <= enb_d;
      enc_q     <= enc_d;
      enshift_q <= enshift_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      led_q     <= led_d;
    end
  end

  assign ena       = ena_q;
  assign enb       = enb_q;
  assign enc       = enc_q;
  assign enshift   = enshift_q;
  assign selectMux = sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign state_led = led_q;

endmodule

// File: tb/tb_datapath_seq_ctrl.sv
// Testbench for datapath_seq_ctrl. A reference model holds the queue of
// state codes still to come. Each accepted start expands to the full
// schedule 1,2,3,4*n,5,6*DONE_HOLD, and an abort empties the queue.
module tb_datapath_seq_ctrl;
  localparam int SHIFT_W   = 3;
  localparam int DONE_HOLD = 3;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [SHIFT_W-1:0] nshift;
  logic ena, enb, enc, enshift, selectMux, busy, done;
  logic [2:0] state_led;

  int checks   = 0;
  int failures = 0;

  int exp_q[$];
  bit prev_start;

  datapath_seq_ctrl #(.SHIFT_W(SHIFT_W), .DONE_HOLD(DONE_HOLD)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .nshift(nshift),
    .ena(ena), .enb(enb), .enc(enc), .enshift(enshift), .selectMux(selectMux),
    .busy(busy), .done(done), .state_led(state_led)
  );

  always #5 clk = ~clk;

  // Advance the model by one rising edge, using the inputs present at that edge.
  function automatic void model_edge();
    if (exp_q.size() == 0) begin
      if (start && !prev_start) begin
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(3);
        for (int i = 0; i < int'(nshift); i++) exp_q.push_back(4);
        exp_q.push_back(5);
        for (int i = 0; i < DONE_HOLD; i++) exp_q.push_back(6);
      end
    end else if (abort) begin
      exp_q.delete();
    end else begin
      void'(exp_q.pop_front());
    end
    prev_start = start;
  endfunction

  // Drive one cycle of inputs, clock it, and return the observed and expected
  // output bundles plus the enable exclusivity flag.
  task automatic step(input logic s, input logic a, input logic [SHIFT_W-1:0] n,
                      output logic [9:0] obs, output logic [9:0] exv, output bit oh);
    int e;
    start = s; abort = a; nshift = n;
    @(posedge clk);
    model_edge();
    #1;
    e   = (exp_q.size() != 0) ? exp_q[0] : 0;
    obs = {state_led, ena, enb, enc, enshift, selectMux, busy, done};
    exv = {3'(e), e == 1, e == 2, e == 5, e == 4, (e >= 3 && e <= 5), (e >= 1 && e <= 5), e == 6};
    oh  = (int'(ena) + int'(enb) + int'(enc) + int'(enshift)) <= 1;
  endtask

  task automatic test_reset();
    rst = 1'b1; abort = 1'b0; nshift = '0;
    start = 1'b1; #3 start = 1'b0; #3 start = 1'b1; #3 start = 1'b0;
    checks++;
    if ({state_led, ena, enb, enc, enshift, selectMux, busy, done} !== 10'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", {state_led, ena, enb, enc, enshift, selectMux, busy, done}, 10'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    prev_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      logic [9:0] o, x; bit oh;
      step(1'b0, c == 2, 3'($urandom), o, x, oh);
      checks++;
      if (o !== x || o !== 10'd0) begin
        failures++;
        $display("FAIL reset_idle cyc%0d got=%b exp=%b", c, o, 10'd0);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_nshift3();
    int seq[11] = '{1, 2, 3, 4, 4, 4, 5, 6, 6, 6, 0};
    int nsh = 0, ndone = 0, nbusy = 0;
    for (int c = 0; c < 13; c++) begin
      logic [9:0] o, x; bit oh;
      step(c == 0, 1'b0, (c == 0) ? 3'd3 : 3'($urandom), o, x, oh);
      checks++;
      if (o !== x) begin failures++; $display("FAIL nshift3_model cyc%0d got=%b exp=%b", c, o, x); end
      checks++;
      if (!oh) begin failures++; $display("FAIL nshift3_onehot cyc%0d got=%b exp=onehot", c, {ena, enb, enc, enshift}); end
      if (c < 11) begin
        checks++;
        if (int'(state_led) != seq[c]) begin
          failures++; $display("FAIL nshift3_led cyc%0d got=%0d exp=%0d", c, state_led, seq[c]);
        end
      end
      nsh += int'(enshift); ndone += int'(done); nbusy += int'(busy);
    end
    checks++;
    if (nsh != 3) begin failures++; $display("FAIL nshift3_shifts got=%0d exp=3", nsh); end
    checks++;
    if (ndone != DONE_HOLD) begin failures++; $display("FAIL nshift3_done got=%0d exp=%0d", ndone, DONE_HOLD); end
    checks++;
    if (nbusy != 7) begin failures++; $display("FAIL nshift3_busy got=%0d exp=7", nbusy); end
    $display("test_nshift3 done");
  endtask

  task automatic test_nshift_edge(input logic [SHIFT_W-1:0] n);
    int nsh = 0, nbusy = 0;
    for (int c = 0; c < int'(n) + 10; c++) begin
      logic [9:0] o, x; bit oh;
      step(c == 0, 1'b0, (c == 0) ? n : 3'($urandom), o, x, oh);
      checks++;
      if (o !== x) begin failures++; $display("FAIL nshift%0d_model cyc%0d got=%b exp=%b", n, c, o, x); end
      checks++;
      if (!oh) begin failures++; $display("FAIL nshift%0d_onehot cyc%0d got=%b exp=onehot", n, c, {ena, enb, enc, enshift}); end
      nsh += int'(enshift); nbusy += int'(busy);
    end
    checks++;
    if (nsh != int'(n)) begin failures++; $display("FAIL nshift%0d_shifts got=%0d exp=%0d", n, nsh, n); end
    checks++;
    if (nbusy != int'(n) + 4) begin failures++; $display("FAIL nshift%0d_busy got=%0d exp=%0d", n, nbusy, int'(n) + 4); end
    $display("test_nshift_edge n=%0d done", n);
  endtask

  // Start held high for 20 cycles, then a second edge arriving during SHIFT.
  task automatic test_start_retrigger();
    int runs = 0;
    for (int c = 0; c < 40; c++) begin
      logic [9:0] o, x; bit oh; logic s;
      s = (c < 20) || (c == 25) || (c == 26);  // c=25 edge lands in SHIFT of run 2
      if (c == 21) s = 1'b1;                   // fresh edge in IDLE starts run 2
      step(s, 1'b0, 3'd3, o, x, oh);
      checks++;
      if (o !== x) begin failures++; $display("FAIL retrigger_model cyc%0d got=%b exp=%b", c, o, x); end
      checks++;
      if (!oh) begin failures++; $display("FAIL retrigger_onehot cyc%0d got=%b exp=onehot", c, {ena, enb, enc, enshift}); end
      runs += int'(state_led == 3'd1);
    end
    checks++;
    if (runs != 2) begin failures++; $display("FAIL retrigger_runs got=%0d exp=2", runs); end
    $display("test_start_retrigger done");
  endtask

  task automatic test_abort_shift();
    int nenc = 0, ndone = 0, nsh = 0;
    for (int c = 0; c < 24; c++) begin
      logic [9:0] o, x; bit oh;
      // Run 1 (nshift=4): the edge of step 6 sees SHIFT with cnt=2 remaining.
      step((c == 0) || (c == 9), c == 6, 3'd4, o, x, oh);
      checks++;
      if (o !== x) begin failures++; $display("FAIL abort_shift_model cyc%0d got=%b exp=%b", c, o, x); end
      checks++;
      if (!oh) begin failures++; $display("FAIL abort_shift_onehot cyc%0d got=%b exp=onehot", c, {ena, enb, enc, enshift}); end
      if (c == 6) begin
        checks++;
        if (state_led !== 3'd0) begin failures++; $display("FAIL abort_shift_idle got=%0d exp=0", state_led); end
      end
      if (c < 9) begin nenc += int'(enc); ndone += int'(done); end
      else nsh += int'(enshift);
    end
    checks++;
    if (nenc != 0 || ndone != 0) begin failures++; $display("FAIL abort_shift_leak got=enc%0d/done%0d exp=0/0", nenc, ndone); end
    checks++;
    if (nsh != 4) begin failures++; $display("FAIL abort_shift_rerun got=%0d exp=4", nsh); end
    $display("test_abort_shift done");
  endtask

  task automatic test_abort_done_and_idle();
    for (int c = 0; c < 16; c++) begin
      logic [9:0] o, x; bit oh;
      // nshift=0: DONE is entered on step 4. Abort on step 5 truncates it.
      // Step 8 has abort and a start edge together while IDLE.
      step((c == 0) || (c == 8), (c == 5) || (c == 8), 3'd0, o, x, oh);
      checks++;
      if (o !== x) begin failures++; $display("FAIL abort_done_model cyc%0d got=%b exp=%b", c, o, x); end
      checks++;
      if (!oh) begin failures++; $display("FAIL abort_done_onehot cyc%0d got=%b exp=onehot", c, {ena, enb, enc, enshift}); end
      if (c == 8) begin
        checks++;
        if (state_led !== 3'd1) begin failures++; $display("FAIL abort_start_idle got=%0d exp=1", state_led); end
      end
    end
    $display("test_abort_done_and_idle done");
  endtask

  task automatic test_reset_mid();
    logic [9:0] o, x; bit oh;
    step(1'b1, 1'b0, 3'd5, o, x, oh);
    step(1'b0, 1'b0, 3'd5, o, x, oh);   // now in LOAD_B
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({state_led, ena, enb, enc, enshift, selectMux, busy, done} !== 10'd0) begin
      failures++;
      $display("FAIL reset_mid got=%b exp=%b", {state_led, ena, enb, enc, enshift, selectMux, busy, done}, 10'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    prev_start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 3'd5, o, x, oh);
      checks++;
      if (o !== x) begin failures++; $display("FAIL reset_mid_after cyc%0d got=%b exp=%b", c, o, x); end
    end
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    logic s = 1'b0;
    for (int c = 0; c < 400; c++) begin
      logic [9:0] o, x; bit oh;
      if ($urandom_range(0, 3) == 0) s = ~s;
      step(s, $urandom_range(0, 15) == 0, 3'($urandom), o, x, oh);
      checks++;
      if (o !== x) begin failures++; $display("FAIL random_model cyc%0d got=%b exp=%b", c, o, x); end
      checks++;
      if (!oh) begin failures++; $display("FAIL random_onehot cyc%0d got=%b exp=onehot", c, {ena, enb, enc, enshift}); end
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; nshift = '0;
    prev_start = 1'b0;
    test_reset();
    test_nshift3();
    test_nshift_edge(3'd0);
    test_nshift_edge(3'd7);
    test_start_retrigger();
    test_abort_shift();
    test_abort_done_and_idle();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/datapath_seq_ctrl.md
Name: datapath_seq_ctrl

Overview:
Moore controller that sequences the four-register datapath through one load/shift/store operation per start request. It drives the datapath's register enables (ena, enb, enc, enshift) and mux select (selectMux) in a fixed order, so no bench or top level has to toggle them by hand. It sits beside the datapath inside the system top and exposes busy/done/state status for the board LEDs.

Parameters:
SHIFT_W, 3, width of nshift input and internal shift counter
DONE_HOLD, 3, cycles done stays high before returning to IDLE (>=1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  level request; rising edge detected internally
abort  input  1  synchronous cancel of an operation in progress
nshift  input  SHIFT_W  number of shift cycles, sampled on accepted start
ena  output  1  load enable, register A
enb  output  1  load enable, register B
enc  output  1  load enable, result register C
enshift  output  1  shift-register enable
selectMux  output  1  datapath mux select (0 = data input path, 1 = register/shift path)
busy  output  1  high in LOAD_A..STORE_C
done  output  1  high in DONE
state_led  output  3  current state code

Behaviour:
- State codes: IDLE=0, LOAD_A=1, LOAD_B=2, MUX=3, SHIFT=4, STORE_C=5, DONE=6; 7 unused, recovers to IDLE next cycle.
- Reset (async, any time incl. mid-operation): state=IDLE, start_q=0, cnt=0, hold counter=0. All outputs 0 immediately.
- Outputs are decoded from the registered state only (Moore). They are valid for the whole cycle in which the state is held.
- Start edge: start_edge = start & ~start_q, where start_q is start registered each clk.
  - Only accepted in IDLE. Edges in any other state are dropped, not queued.
  - Start held high never retriggers; it must go low, then high again.
- Accept: at the posedge where state is IDLE and start_edge is 1, state<=LOAD_A and cnt<=nshift. ena is high in the following cycle (1-cycle latency).
- Per-state outputs and transitions:
  - IDLE: all outputs 0. Stays in IDLE until start_edge.
  - LOAD_A: ena=1, selectMux=0. Next state LOAD_B.
  - LOAD_B: enb=1, selectMux=0. Next state MUX.
  - MUX: selectMux=1, no enables (settle cycle). Next state SHIFT if cnt!=0, else STORE_C.
  - SHIFT: selectMux=1, enshift=1, cnt<=cnt-1. Leaves to STORE_C on the cycle where cnt==1, so exactly nshift SHIFT cycles.
  - STORE_C: enc=1, selectMux=1. Next state DONE and hold counter cleared.
  - DONE: done=1, all enables 0, selectMux=0. Stays DONE_HOLD cycles, then IDLE.
- Mutual exclusion: at most one of ena/enb/enc/enshift is high in any cycle.
- busy is high in states 1..5 only.
- Busy length: nshift+4 cycles. Total from accept to IDLE: nshift+4+DONE_HOLD cycles.
- nshift changes after accept are ignored. nshift=0 skips SHIFT entirely.
- Max nshift (2^SHIFT_W-1 = 7): counter must not wrap; exactly 7 shift cycles.
- abort:
  - Sampled in any non-IDLE state; at that posedge state<=IDLE and all outputs drop next cycle.
  - Abort in DONE also goes to IDLE immediately, truncating done.
  - Abort in IDLE has no effect.
  - Abort and start_edge high in the same IDLE cycle: start is accepted (abort ignored in IDLE).
  - Abort and a state exit in the same cycle: abort wins, so no done pulse.
- A start edge arriving in the last DONE cycle is dropped. The next accept needs a fresh edge while in IDLE.

Test Plan:
- Reset: rst=1 for 10 ns with start toggling -> all outputs 0, state_led=0. Then rst=0 mid-cycle -> stays IDLE until a clean start edge.
- nshift=3, start pulse -> ena@c1, enb@c2, selectMux only@c3, enshift+selectMux@c4-c6, enc@c7, done@c8-c10 (DONE_HOLD=3), IDLE@c11. busy high c1-c7. state_led sequence 1,2,3,4,4,4,5,6,6,6,0.
- nshift=0 -> MUX goes straight to STORE_C. enshift never asserted, busy=4 cycles. nshift=7 -> exactly 7 enshift cycles, no wrap.
- Start held high 20 cycles -> exactly one operation. Second start edge during SHIFT -> ignored, no second run.
- Abort during SHIFT (cnt=2 remaining) -> IDLE next cycle, done never asserts, enc never asserts. A fresh start then runs a full sequence.
- Assert rst during LOAD_B -> all outputs 0 within the same cycle (async). After release, IDLE and no spurious enables. Every cycle of every test checks the one-hot-or-zero enable property.
